// File: rtl/adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_pkg: shared widths and reference sum for the 3+3+cin adder.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package adder_pkg;

  localparam int DEFAULT_WIDTH = 3;

  function automatic logic [DEFAULT_WIDTH:0] golden_add(
    input logic [DEFAULT_WIDTH-1:0] a,
    input logic [DEFAULT_WIDTH-1:0] b,
    input logic                     cin
  );
    golden_add = {1'b0, a} + {1'b0, b} + {{DEFAULT_WIDTH{1'b0}}, cin};
  endfunction

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | full_adder: one-bit sum/carry cell of the ripple chain.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/adder_13_blk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_13_blk: registered ripple-carry a + b + cin with valid flag.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module adder_13_blk
  import adder_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   sum,
  output logic             out_valid
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_bits;
  logic [WIDTH:0]   w_sum;
  logic             r_valid;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_carry[i]),
      .s  (w_bits[i]),
      .co (w_carry[i+1])
    );
  end

  assign w_sum = {w_carry[WIDTH], w_bits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= 1'b0;
    else        r_valid <= in_valid;
  end

  if (OUT_REG) begin : g_out_reg
    logic [WIDTH:0] r_sum;

    // Capture only on valid so idle (possibly unknown) operands never reach sum.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_sum <= '0;
      else if (in_valid) r_sum <= w_sum;
    end

    assign sum = r_sum;
  end else begin : g_out_comb
    // Mask idle/reset cycles so unknown operands cannot leak downstream.
    assign sum = (in_valid && rst_n) ? w_sum : '0;
  end

  assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_adder_13_blk.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_adder_13_blk: directed vector bench for adder_13_blk (OUT_REG=1). |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_adder_13_blk;

  typedef struct {
    string      name;
    logic [2:0] a;
    logic [2:0] b;
    logic       cin;
    logic [3:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [2:0] a;
  logic [2:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       out_valid;

  int errors = 0;
  int checks = 0;

  adder_13_blk #(.WIDTH(3), .OUT_REG(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sum       (sum),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  // Drive on the falling edge, sample 1 time unit after the next rising edge.
  task automatic apply(input logic v, input logic [2:0] ta, input logic [2:0] tb_, input logic tc);
    @(negedge clk);
    in_valid = v;
    a        = ta;
    b        = tb_;
    cin      = tc;
    @(posedge clk);
    #1;
  endtask

  vec_t spots[6];
  logic [3:0] prev;
  logic [6:0] pi;

  initial begin
    spots[0] = '{"spot_0000001",  3'd0, 3'd0, 1'b1, 4'b0001};
    spots[1] = '{"spot_0010010",  3'd1, 3'd1, 1'b0, 4'b0010};
    spots[2] = '{"spot_1001000",  3'd4, 3'd4, 1'b0, 4'b1000};
    spots[3] = '{"spot_1111111",  3'd7, 3'd7, 1'b1, 4'b1111};
    spots[4] = '{"carry_ripple",  3'd3, 3'd1, 1'b1, 4'b0101};
    spots[5] = '{"carry_out_only",3'd7, 3'd1, 1'b0, 4'b1000};

    // Reset held with a live maximal operand set.
    rst_n = 1'b0; in_valid = 1'b1; a = 3'd7; b = 3'd7; cin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", sum, 4'b0000);
    check("reset_valid", {3'b0, out_valid}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_after_reset", sum, 4'b1111);
    check("first_valid", {3'b0, out_valid}, 4'd1);

    // Exhaustive sweep; sum must still show the previous result before the edge.
    prev = 4'b1111;
    for (int i = 0; i < 128; i++) begin
      pi = i[6:0];
      @(negedge clk);
      in_valid = 1'b1;
      a   = pi[6:4];
      b   = pi[3:1];
      cin = pi[0];
      #1;
      check($sformatf("latency_%0d", i), sum, prev);
      @(posedge clk);
      #1;
      prev = 4'(int'(pi[6:4]) + int'(pi[3:1]) + int'(pi[0]));
      check($sformatf("sweep_%0d", i), sum, prev);
      check($sformatf("sweep_valid_%0d", i), {3'b0, out_valid}, 4'd1);
    end

    for (int i = 0; i < 6; i++) begin
      apply(1'b1, spots[i].a, spots[i].b, spots[i].cin);
      check(spots[i].name, sum, spots[i].exp);
    end

    // Hold: idle cycles with arbitrary operands leave the sum untouched.
    apply(1'b1, 3'd2, 3'd3, 1'b0);
    check("hold_load", sum, 4'b0101);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      check($sformatf("hold_sum_%0d", i), sum, 4'b0101);
      check($sformatf("hold_valid_%0d", i), {3'b0, out_valid}, 4'd0);
    end

    // Mid-stream reset clears outputs between edges.
    apply(1'b1, 3'd5, 3'd5, 1'b1);
    check("stream_pre_reset", sum, 4'b1011);
    @(negedge clk);
    a = 3'd6; b = 3'd6; cin = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_sum", sum, 4'b0000);
    check("async_reset_valid", {3'b0, out_valid}, 4'd0);
    @(posedge clk);
    #1;
    check("reset_held_sum", sum, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    apply(1'b1, 3'd6, 3'd3, 1'b1);
    check("post_reset_sum", sum, 4'b1010);
    check("post_reset_valid", {3'b0, out_valid}, 4'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_13_blk.md
Name: adder_13_blk

Overview:
Registered 3-bit + 3-bit + carry-in adder producing a 4-bit sum (carry-out as the MSB). It is the synchronous wrapper of the 7-input/4-output adder partition used in the approximate-logic flow. The exhaustive 128-vector truth table of the combinational core is the golden model. It sits between partition input registers and downstream partition logic.

Parameters:
- WIDTH, 3, operand width; sum width is WIDTH+1. Default 3 gives the 7-in/4-out partition.
- OUT_REG, 1, 1 = sum registered (latency 1); 0 = combinational sum, with only valid registered.

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid this cycle
- a  in  WIDTH  operand A; bit order maps to pi[6:4] of the 7-bit vector (a[2]=pi[6])
- b  in  WIDTH  operand B; maps to pi[3:1] (b[2]=pi[3])
- cin  in  1  carry-in; maps to pi[0]
- sum  out  WIDTH+1  {carry_out, sum bits}; maps to po[3:0] (sum[3]=po[3]=carry-out)
- out_valid  out  1  sum valid

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Function: sum = a + b + cin, computed as an unsigned exact sum with no overflow. The maximum is 7+7+1=15, so it fits in 4 bits.
- Arithmetic: ripple-carry chain of WIDTH full adders.
  - Bit i: s_i = a_i ^ b_i ^ c_i; c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = cin; sum[WIDTH] = c_WIDTH.
- Reset: while rst_n=0, sum=0 and out_valid=0, asynchronously. Release is synchronous to the next clk edge.
- OUT_REG=1:
  - On each rising edge with in_valid=1: sum <= a+b+cin; out_valid <= 1.
  - With in_valid=0: sum holds its last value; out_valid <= 0.
  - Latency is exactly 1 cycle. A new operand can be accepted every cycle (throughput 1).
- OUT_REG=0: sum = a+b+cin combinationally; out_valid <= in_valid registered.
- No backpressure and no stall input.
- Back-to-back valid inputs each produce a result one cycle later, in order.
- Reset asserted mid-stream discards the in-flight result.
- X on a/b/cin while in_valid=0 must not propagate to sum.

Decomposition:
- Shared package adder_pkg:
  - localparam DEFAULT_WIDTH=3
  - function golden_add(a,b,cin) returning WIDTH+1 bits, used by the bench scoreboard.
- One natural sub-module: full_adder (a, b, ci -> s, co), instantiated WIDTH times in a generate loop.
- Top-level holds the valid/sum registers only.

Test Plan:
- Reset: rst_n=0 with in_valid=1, a=7, b=7, cin=1 -> sum=4'b0000, out_valid=0. After release, first edge with valid -> 4'b1111.
- Exhaustive sweep: drive all 128 values of {a,b,cin} = 7'b0000000..7'b1111111 with in_valid=1, one per cycle. Each output one cycle later must equal the golden model. Spot checks:
  - 0000001 -> 0001
  - 0010010 (a=1, b=1, cin=0) -> 0010
  - 1001000 (a=4, b=4) -> 1000
  - 1111111 -> 1111
- Carry ripple: a=3'b011, b=3'b001, cin=1 -> sum=4'b0101.
- Carry-out only: a=7, b=1, cin=0 -> 4'b1000.
- Hold: valid a=2, b=3, cin=0 -> 0101. Then in_valid=0 for 3 cycles with random a/b -> sum stays 0101, out_valid=0.
- Mid-stream reset: stream valid vectors, assert rst_n low between edges -> sum=0 and out_valid=0 immediately. The first post-release valid vector is correct after 1 cycle.
